multicycle_control: RTL and testbench

//  Multi-cycle successor of the single-cycle RV32I main decoder. A Moore FSM sequences each

---
 rtl/rv_ctrl_pkg.sv | 158 +++++++++++++++
 rtl/mem_wait_timer.sv | 39 +++
 rtl/multicycle_control.sv | 117 +++++++++++
 tb/tb_multicycle_control.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/rv_ctrl_pkg.sv
// Shared RV32I control encodings: opcodes, FSM state, mux selects and the
// per-state control word used by the multi-cycle controller.
package rv_ctrl_pkg;

    localparam logic [6:0] OP_R_TYPE = 7'b0110011;
    localparam logic [6:0] OP_I_ALU  = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    localparam logic [1:0] SRC_A_PC     = 2'd0;
    localparam logic [1:0] SRC_A_OLD_PC = 2'd1;
    localparam logic [1:0] SRC_A_RS1    = 2'd2;
    localparam logic [1:0] SRC_B_RS2    = 2'd0;
    localparam logic [1:0] SRC_B_IMM    = 2'd1;
    localparam logic [1:0] SRC_B_FOUR   = 2'd2;

    typedef enum logic [3:0] {
        ST_IDLE     = 4'd0,
        ST_FETCH    = 4'd1,
        ST_DECODE   = 4'd2,
        ST_EXEC_R   = 4'd3,
        ST_EXEC_I   = 4'd4,
        ST_MEM_ADDR = 4'd5,
        ST_MEM_RD   = 4'd6,
        ST_MEM_WR   = 4'd7,
        ST_WB_ALU   = 4'd8,
        ST_WB_MEM   = 4'd9,
        ST_BRANCH   = 4'd10,
        ST_JAL      = 4'd11,
        ST_JALR     = 4'd12,
        ST_TRAP     = 4'd13
    } state_t;

    typedef enum logic [1:0] {
        ALU_ADD    = 2'b00,
        ALU_BRANCH = 2'b01,
        ALU_RFUNCT = 2'b10,
        ALU_IFUNCT = 2'b11
    } alu_op_t;

    typedef enum logic [1:0] {
        RES_ALU_OUT    = 2'd0,
        RES_MEM_DATA   = 2'd1,
        RES_ALU_DIRECT = 2'd2
    } result_src_t;

    typedef enum logic [1:0] {
        JUMP_NONE = 2'b00,
        JUMP_JAL  = 2'b01,
        JUMP_JALR = 2'b11
    } jump_t;

    // ready_qual marks states whose pc_write/ir_write/instr_done wait on mem_ready
    typedef struct packed {
        logic        pc_write;
        logic        ir_write;
        logic        i_or_d;
        logic        mem_req;
        logic        mem_we;
        logic [1:0]  alu_src_a;
        logic [1:0]  alu_src_b;
        alu_op_t     alu_op;
        result_src_t result_src;
        logic        reg_write;
        logic        branch;
        jump_t       jump;
        logic        instr_done;
        logic        trap;
        logic        ready_qual;
    } ctrl_t;

    function automatic ctrl_t state_ctrl(state_t s);
        ctrl_t c;
        c = '0;
        case (s)
            ST_FETCH: begin
                c.mem_req    = 1'b1;
                c.ir_write   = 1'b1;
                c.pc_write   = 1'b1;
                c.ready_qual = 1'b1;
                c.alu_src_a  = SRC_A_PC;
                c.alu_src_b  = SRC_B_FOUR;
                c.result_src = RES_ALU_DIRECT;
            end
            ST_DECODE: begin
                c.alu_src_a = SRC_A_OLD_PC;
                c.alu_src_b = SRC_B_IMM;
            end
            ST_EXEC_R: begin
                c.alu_src_a = SRC_A_RS1;
                c.alu_src_b = SRC_B_RS2;
                c.alu_op    = ALU_RFUNCT;
            end
            ST_EXEC_I: begin
                c.alu_src_a = SRC_A_RS1;
                c.alu_src_b = SRC_B_IMM;
                c.alu_op    = ALU_IFUNCT;
            end
            ST_MEM_ADDR: begin
                c.alu_src_a = SRC_A_RS1;
                c.alu_src_b = SRC_B_IMM;
            end
            ST_MEM_RD: begin
                c.mem_req = 1'b1;
                c.i_or_d  = 1'b1;
            end
            ST_MEM_WR: begin
                c.mem_req    = 1'b1;
                c.mem_we     = 1'b1;
                c.i_or_d     = 1'b1;
                c.instr_done = 1'b1;
                c.ready_qual = 1'b1;
            end
            ST_WB_ALU: begin
                c.reg_write  = 1'b1;
                c.result_src = RES_ALU_OUT;
                c.instr_done = 1'b1;
            end
            ST_WB_MEM: begin
                c.reg_write  = 1'b1;
                c.result_src = RES_MEM_DATA;
                c.instr_done = 1'b1;
            end
            ST_BRANCH: begin
                c.alu_src_a  = SRC_A_RS1;
                c.alu_src_b  = SRC_B_RS2;
                c.alu_op     = ALU_BRANCH;
                c.branch     = 1'b1;
                c.result_src = RES_ALU_OUT;
                c.instr_done = 1'b1;
            end
            ST_JAL: begin
                c.jump       = JUMP_JAL;
                c.pc_write   = 1'b1;
                c.reg_write  = 1'b1;
                c.alu_src_a  = SRC_A_OLD_PC;
                c.alu_src_b  = SRC_B_FOUR;
                c.result_src = RES_ALU_OUT;
                c.instr_done = 1'b1;
            end
            ST_JALR: begin
                c.jump       = JUMP_JALR;
                c.pc_write   = 1'b1;
                c.reg_write  = 1'b1;
                c.alu_src_a  = SRC_A_OLD_PC;
                c.alu_src_b  = SRC_B_FOUR;
                c.instr_done = 1'b1;
            end
            ST_TRAP: c.trap = 1'b1;
            default: ;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Counts memory wait cycles for one access and flags when the limit is hit.
// LIMIT of 0 disables expiry; the counter then saturates instead of wrapping.
module mem_wait_timer #(
    parameter int unsigned LIMIT = 15
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic inc,
    output logic expired
);

    localparam int unsigned   CNT_W      = (LIMIT == 0) ? 1 : $clog2(LIMIT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] LIMIT_V = CNT_W'(LIMIT);
    localparam bit            TIMEOUT_EN = (LIMIT != 0);

    logic [CNT_W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (inc && (count_q != CNT_MAX)) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired = TIMEOUT_EN && (count_q == LIMIT_V);

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle RV32I main controller: Moore FSM sequencing FETCH..WB with a
// memory handshake, wait timeout and sticky trap on illegal opcodes/stalls.
module multicycle_control
    import rv_ctrl_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 15,
    parameter int unsigned ALU_OP_W    = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [6:0]          opcode,
    input  logic                mem_ready,
    output logic                pc_write,
    output logic                ir_write,
    output logic                i_or_d,
    output logic                mem_req,
    output logic                mem_we,
    output logic [1:0]          alu_src_a,
    output logic [1:0]          alu_src_b,
    output logic [ALU_OP_W-1:0] alu_op,
    output logic [1:0]          result_src,
    output logic                reg_write,
    output logic                branch,
    output logic [1:0]          jump,
    output logic                instr_done,
    output logic                trap
);

    state_t state_q, state_d;
    ctrl_t  ctrl_q, ctrl_d;
    logic   is_store_q, is_store_d;
    logic   wait_clear, wait_inc, wait_expired;
    logic   qual_ok;

    assign wait_inc   = ctrl_q.mem_req && !mem_ready;
    assign wait_clear = (state_d != state_q) &&
                        (state_d inside {ST_FETCH, ST_MEM_RD, ST_MEM_WR});

    mem_wait_timer #(
        .LIMIT(MEM_TIMEOUT)
    ) u_wait_timer (
        .clk    (clk),
        .reset  (reset),
        .clear  (wait_clear),
        .inc    (wait_inc),
        .expired(wait_expired)
    );

    always_comb begin
        state_d    = state_q;
        is_store_d = is_store_q;
        case (state_q)
            ST_IDLE:  state_d = ST_FETCH;
            ST_FETCH: begin
                if (mem_ready)         state_d = ST_DECODE;
                else if (wait_expired) state_d = ST_TRAP;
            end
            ST_DECODE: begin
                is_store_d = (opcode == OP_STORE);
                case (opcode)
                    OP_R_TYPE:         state_d = ST_EXEC_R;
                    OP_I_ALU:          state_d = ST_EXEC_I;
                    OP_LOAD, OP_STORE: state_d = ST_MEM_ADDR;
                    OP_BRANCH:         state_d = ST_BRANCH;
                    OP_JAL:            state_d = ST_JAL;
                    OP_JALR:           state_d = ST_JALR;
                    default:           state_d = ST_TRAP;
                endcase
            end
            ST_EXEC_R, ST_EXEC_I: state_d = ST_WB_ALU;
            ST_MEM_ADDR: state_d = is_store_q ? ST_MEM_WR : ST_MEM_RD;
            ST_MEM_RD: begin
                if (mem_ready)         state_d = ST_WB_MEM;
                else if (wait_expired) state_d = ST_TRAP;
            end
            ST_MEM_WR: begin
                if (mem_ready)         state_d = ST_FETCH;
                else if (wait_expired) state_d = ST_TRAP;
            end
            ST_WB_ALU, ST_WB_MEM, ST_BRANCH, ST_JAL, ST_JALR: state_d = ST_FETCH;
            ST_TRAP:  state_d = ST_TRAP;
            default:  state_d = ST_TRAP;
        endcase
        ctrl_d = state_ctrl(state_d);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            ctrl_q     <= '0;
            is_store_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            ctrl_q     <= ctrl_d;
            is_store_q <= is_store_d;
        end
    end

    // Control word is registered from next state; only the handshake-gated
    // enables see mem_ready combinationally so they fire on the completing edge.
    assign qual_ok    = !ctrl_q.ready_qual || mem_ready;
    assign pc_write   = ctrl_q.pc_write && qual_ok;
    assign ir_write   = ctrl_q.ir_write && qual_ok;
    assign instr_done = ctrl_q.instr_done && qual_ok;
    assign i_or_d     = ctrl_q.i_or_d;
    assign mem_req    = ctrl_q.mem_req;
    assign mem_we     = ctrl_q.mem_we;
    assign alu_src_a  = ctrl_q.alu_src_a;
    assign alu_src_b  = ctrl_q.alu_src_b;
    assign alu_op     = ALU_OP_W'(ctrl_q.alu_op);
    assign result_src = ctrl_q.result_src;
    assign reg_write  = ctrl_q.reg_write;
    assign branch     = ctrl_q.branch;
    assign jump       = ctrl_q.jump;
    assign trap       = ctrl_q.trap;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: three instances (timeout 15, 4, 0)
// share stimulus; a per-state output model feeds a scoreboard queue.
module tb_multicycle_control;

    typedef enum {
        S_IDLE, S_FETCH, S_DECODE, S_EXEC_R, S_EXEC_I, S_MEM_ADDR, S_MEM_RD,
        S_MEM_WR, S_WB_ALU, S_WB_MEM, S_BRANCH, S_JAL, S_JALR, S_TRAP
    } tst_t;

    localparam logic [6:0] OPC_R   = 7'b0110011;
    localparam logic [6:0] OPC_I   = 7'b0010011;
    localparam logic [6:0] OPC_LD  = 7'b0000011;
    localparam logic [6:0] OPC_ST  = 7'b0100011;
    localparam logic [6:0] OPC_BR  = 7'b1100011;
    localparam logic [6:0] OPC_JAL = 7'b1101111;
    localparam logic [6:0] OPC_JR  = 7'b1100111;
    localparam logic [6:0] OPC_BAD = 7'b1111111;

    logic        clk = 1'b0;
    logic        reset;
    logic        mem_ready;
    logic [6:0]  opcode;
    logic [18:0] got [3];
    logic [18:0] sb [$];
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        logic       pc_write, ir_write, i_or_d, mem_req, mem_we;
        logic       reg_write, branch, instr_done, trap;
        logic [1:0] alu_src_a, alu_src_b, alu_op, result_src, jump;

        multicycle_control #(
            .MEM_TIMEOUT((g == 0) ? 15 : ((g == 1) ? 4 : 0)),
            .ALU_OP_W   (2)
        ) dut (
            .clk       (clk),
            .reset     (reset),
            .opcode    (opcode),
            .mem_ready (mem_ready),
            .pc_write  (pc_write),
            .ir_write  (ir_write),
            .i_or_d    (i_or_d),
            .mem_req   (mem_req),
            .mem_we    (mem_we),
            .alu_src_a (alu_src_a),
            .alu_src_b (alu_src_b),
            .alu_op    (alu_op),
            .result_src(result_src),
            .reg_write (reg_write),
            .branch    (branch),
            .jump      (jump),
            .instr_done(instr_done),
            .trap      (trap)
        );

        assign got[g] = {pc_write, ir_write, i_or_d, mem_req, mem_we, alu_src_a,
                         alu_src_b, alu_op, result_src, reg_write, branch, jump,
                         instr_done, trap};
    end

    function automatic logic [18:0] model(tst_t s, logic rdy);
        logic       pcw, irw, iod, req, we, rw, br, done, tr;
        logic [1:0] a, b, op, res, j;
        {pcw, irw, iod, req, we, rw, br, done, tr} = '0;
        {a, b, op, res, j} = '0;
        case (s)
            S_FETCH:    begin req = 1; irw = rdy; pcw = rdy; a = 0; b = 2; res = 2; end
            S_DECODE:   begin a = 1; b = 1; end
            S_EXEC_R:   begin a = 2; b = 0; op = 2'b10; end
            S_EXEC_I:   begin a = 2; b = 1; op = 2'b11; end
            S_MEM_ADDR: begin a = 2; b = 1; end
            S_MEM_RD:   begin req = 1; iod = 1; end
            S_MEM_WR:   begin req = 1; we = 1; iod = 1; done = rdy; end
            S_WB_ALU:   begin rw = 1; res = 0; done = 1; end
            S_WB_MEM:   begin rw = 1; res = 1; done = 1; end
            S_BRANCH:   begin a = 2; b = 0; op = 2'b01; br = 1; done = 1; end
            S_JAL:      begin j = 2'b01; pcw = 1; rw = 1; a = 1; b = 2; done = 1; end
            S_JALR:     begin j = 2'b11; pcw = 1; rw = 1; a = 1; b = 2; done = 1; end
            S_TRAP:     tr = 1;
            default:    ;
        endcase
        return {pcw, irw, iod, req, we, a, b, op, res, rw, br, j, done, tr};
    endfunction

    // Inputs apply to the current cycle; s0..s2 are each instance's state now.
    task automatic step(input logic rst, input logic rdy, input logic [6:0] op,
                        input tst_t s0, input tst_t s1, input tst_t s2, input string tag);
        logic [18:0] exp_v;
        reset     = rst;
        mem_ready = rdy;
        opcode    = op;
        sb.push_back(model(s0, rdy));
        sb.push_back(model(s1, rdy));
        sb.push_back(model(s2, rdy));
        #1;
        for (int i = 0; i < 3; i++) begin
            exp_v  = sb.pop_front();
            checks = checks + 1;
            assert (got[i] === exp_v) else begin
                errors = errors + 1;
                $error("FAIL %s dut%0d: got %b expected %b", tag, i, got[i], exp_v);
            end
        end
        @(negedge clk);
    endtask

    task automatic step1(input logic rst, input logic rdy, input logic [6:0] op,
                         input tst_t s, input string tag);
        step(rst, rdy, op, s, s, s, tag);
    endtask

    initial begin
        tst_t e0, e1;
        reset = 1'b1; mem_ready = 1'b0; opcode = '0;
        @(posedge clk);
        @(negedge clk);

        step1(1, 0, OPC_R, S_IDLE, "rst_c1");
        step1(1, 0, OPC_R, S_IDLE, "rst_c2");
        step1(0, 0, OPC_R, S_IDLE, "idle");

        step1(0, 1, OPC_R, S_FETCH, "r_fetch");
        step1(0, 0, OPC_R, S_DECODE, "r_decode");
        step1(0, 0, OPC_BAD, S_EXEC_R, "r_exec");
        step1(0, 0, OPC_BAD, S_WB_ALU, "r_wb");

        step1(0, 1, OPC_I, S_FETCH, "i_fetch");
        step1(0, 0, OPC_I, S_DECODE, "i_decode");
        step1(0, 0, OPC_I, S_EXEC_I, "i_exec");
        step1(0, 0, OPC_I, S_WB_ALU, "i_wb");

        step1(0, 1, OPC_LD, S_FETCH, "ld_fetch");
        step1(0, 0, OPC_LD, S_DECODE, "ld_decode");
        step1(0, 0, OPC_BAD, S_MEM_ADDR, "ld_addr");
        for (int k = 0; k < 3; k++) step1(0, 0, OPC_BAD, S_MEM_RD, "ld_wait");
        step1(0, 1, OPC_BAD, S_MEM_RD, "ld_ready");
        step1(0, 0, OPC_BAD, S_WB_MEM, "ld_wb");

        step1(0, 0, OPC_ST, S_FETCH, "st_fetch_wait");
        step1(0, 1, OPC_ST, S_FETCH, "st_fetch");
        step1(0, 0, OPC_ST, S_DECODE, "st_decode");
        step1(0, 0, OPC_LD, S_MEM_ADDR, "st_addr");
        step1(0, 1, OPC_LD, S_MEM_WR, "st_done");

        step1(0, 1, OPC_JAL, S_FETCH, "jal_fetch");
        step1(0, 0, OPC_JAL, S_DECODE, "jal_decode");
        step1(0, 0, OPC_JAL, S_JAL, "jal");
        step1(0, 1, OPC_JR, S_FETCH, "jalr_fetch");
        step1(0, 0, OPC_JR, S_DECODE, "jalr_decode");
        step1(0, 0, OPC_JR, S_JALR, "jalr");

        step1(0, 1, OPC_ST, S_FETCH, "st2_fetch");
        step1(0, 0, OPC_ST, S_DECODE, "st2_decode");
        step1(0, 0, OPC_ST, S_MEM_ADDR, "st2_addr");
        step1(0, 0, OPC_ST, S_MEM_WR, "st2_wait");
        step1(1, 0, OPC_ST, S_MEM_WR, "st2_rst");
        step1(0, 0, OPC_BR, S_IDLE, "st2_idle");
        step1(0, 1, OPC_BR, S_FETCH, "br_fetch");
        step1(0, 0, OPC_BR, S_DECODE, "br_decode");
        step1(0, 0, OPC_BR, S_BRANCH, "br_exec");

        step1(0, 1, OPC_BAD, S_FETCH, "bad_fetch");
        step1(0, 1, OPC_BAD, S_DECODE, "bad_decode");
        for (int k = 0; k < 4; k++) step1(0, 1, OPC_R, S_TRAP, "bad_trap");

        step1(1, 0, OPC_R, S_TRAP, "to_rst");
        step1(0, 0, OPC_R, S_IDLE, "to_idle");
        for (int k = 1; k <= 25; k++) begin
            e0 = (k <= 16) ? S_FETCH : S_TRAP;
            e1 = (k <= 5)  ? S_FETCH : S_TRAP;
            step(0, 0, OPC_R, e0, e1, S_FETCH, "timeout");
        end
        step(1, 0, OPC_R, S_TRAP, S_TRAP, S_FETCH, "trap_rst");
        step1(0, 0, OPC_R, S_IDLE, "post_idle");
        step1(0, 1, OPC_R, S_FETCH, "post_fetch");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
